instr_prefetch_queue: RTL and testbench
=======================================

# instr_prefetch_queue

Instruction prefetch queue directly upstream of the pipelined CPU's IF stage. It issues sequential fetch requests to a slow instruction memory over a req/ack handshake and buffers returned words with their addresses in a small FIFO. IF consumes the words through a valid/ready port. A branch or jump redirect flushes the queue and restarts fetching at the target.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- ADDR_W, 8: instruction address width.
- DATA_W, 16: instruction word width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low.
- enable  in  1  fetch permit; low blocks new requests, and an outstanding request still completes.
- flush  in  1  redirect: empties the queue and sets the fetch address.
- flush_pc  in  ADDR_W  redirect target, sampled when flush=1.
- deq_ready  in  1  IF accepts the head entry this cycle.
- deq_valid  out  1  head entry present.
- deq_data  out  DATA_W  head instruction word.
- deq_pc  out  ADDR_W  address of the head word.
- mem_req  out  1  fetch request.
- mem_addr  out  ADDR_W  fetch address.
- mem_ack  in  1  one-cycle pulse; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_W  fetched word.
- fetch_stopped  out  1  fetch halted after a HALT word.

## Operation
- Storage: circular buffer of {pc, word} with read/write pointers and a count of width clog2(DEPTH+1).
- Dequeue happens when deq_valid and deq_ready are both high at a clock edge.
- Enqueue happens when mem_ack is high at an edge in state WAIT.
- Fetch FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; the returned data is kept.
  - DISCARD: request outstanding; the returned data is dropped.
  - STOP: fetch halted; only when HALT_STOP is enabled.
- Free space at an edge means count + enq − deq < DEPTH.
- IDLE → WAIT when enable=1, flush=0 and there is free space. At that edge: mem_req←1, mem_addr←fetch_pc.
- WAIT with mem_ack:
  - Enqueue {mem_addr, mem_rdata}; fetch_pc←mem_addr+1, wrapping mod 2^ADDR_W.
  - If enable=1 and there is still free space, stay in WAIT with mem_addr←mem_addr+1 and mem_req held high (back-to-back fetch).
  - Otherwise go to IDLE with mem_req←0.
- While a request is outstanding, mem_req and mem_addr are held stable until the ack.
- flush=1:
  - Queue is emptied at that edge (pointers and count←0); fetch_pc←flush_pc.
  - In WAIT without ack: go to DISCARD; the old request stays asserted until its ack.
  - In IDLE, STOP, or WAIT with a same-cycle ack: the returned data is dropped. If enable=1, go directly to WAIT with mem_addr=flush_pc; otherwise go to IDLE.
  - In DISCARD: fetch_pc is updated and the state stays DISCARD.
- DISCARD with mem_ack: drop the data; go to WAIT at fetch_pc if enable=1, otherwise IDLE.
- Flush beats a simultaneous dequeue: the dequeue is ignored.
- mem_ack in IDLE or STOP is ignored.

## Timing
- Reset values:
  - Outputs: mem_req=0, mem_addr=0, deq_valid=0, deq_data=0, deq_pc=0, fetch_stopped=0.
  - Internal: fetch_pc=0, state IDLE, all storage entries 0.
- Reset is asynchronous at any point. An ack pending at reset is lost; after reset it arrives in IDLE and is ignored.
- First mem_req rises at the first clock edge after reset release, provided enable=1.
- Enqueue to deq_valid: 1 cycle (word captured at the ack edge, visible after it).
- deq_valid is high exactly when count≠0, decoded from registers.
- deq_data and deq_pc come from the head entry and change only at clock edges.
- Sustained throughput with a 0-wait memory (ack one cycle after req) and continuous dequeue: 1 word per cycle.

## Configuration
- PFQ_HALT_STOP_EN defined:
  - Enqueuing a word with bits [15:11]=5'b00001 (HALT) sends the FSM to STOP and sets fetch_stopped=1. No further requests are issued.
  - Only flush leaves STOP; it clears fetch_stopped at the same edge.
  - Words already enqueued remain dequeueable.
- PFQ_HALT_STOP_EN undefined: the STOP state is absent, fetch_stopped is tied to 0, and HALT words are fetched like any other word.

## Test plan
- Fill: reset release, enable=1, ack 1 cycle after each req, deq_ready=0 → mem_addr sequence 0,1,2,3; then mem_req=0 with count=4; deq_valid=1, deq_pc=0.
- Refill: from full, pulse deq_ready one cycle → head advances to pc 1; exactly one new request at mem_addr=4.
- Flush while waiting: WAIT at addr 2, flush=1 with flush_pc=0x40 → deq_valid=0 next cycle; mem_req stays high at addr 2 until ack; that data is dropped; next request is at 0x40, and deq_pc=0x40 after its ack.
- Flush with same-cycle ack and dequeue: flush=1, flush_pc=0x10, mem_ack=1, deq_ready=1 → queue empty, returned word dropped, next edge mem_addr=0x10 with mem_req=1.
- Wrap: flush_pc=0xFE → fetched addresses 0xFE, 0xFF, 0x00; deq_pc follows the same sequence.
- HALT (PFQ_HALT_STOP_EN): mem_rdata=0x0800 at addr 5 → fetch_stopped=1 and no further mem_req. Dequeue still drains up to pc 5. flush_pc=0x20 clears the stop and fetch resumes at 0x20.

Source files
------------

// File: rtl/instr_prefetch_queue.sv
`default_nettype none
// instr_prefetch_queue: sequential instruction prefetch FIFO with req/ack memory port and redirect flush.
// Define PFQ_HALT_STOP_EN to stop fetching after a HALT word (bits [15:11] == 5'b00001) is enqueued.
module instr_prefetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              deq_ready,
  output logic              deq_valid,
  output logic [DATA_W-1:0] deq_data,
  output logic [ADDR_W-1:0] deq_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fetch_stopped
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

`ifdef PFQ_HALT_STOP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DISCARD = 2'd2, STOP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DISCARD = 2'd2} state_t;
`endif

  state_t              state;
  logic [ADDR_W-1:0]   fetch_pc;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    count;
  logic [ADDR_W-1:0]   pc_mem   [DEPTH];
  logic [DATA_W-1:0]   data_mem [DEPTH];

  logic                do_enq;
  logic                do_deq;
  logic [CNT_W-1:0]    next_count;
  logic                has_space;

  assign deq_valid  = (count != '0);
  assign deq_data   = data_mem[rd_ptr];
  assign deq_pc     = pc_mem[rd_ptr];

  // Flush wins over both a same-cycle dequeue and a same-cycle return.
  assign do_deq     = deq_valid & deq_ready & ~flush;
  assign do_enq     = (state == WAIT) & mem_ack & ~flush;
  assign next_count = count + CNT_W'(do_enq) - CNT_W'(do_deq);
  assign has_space  = (next_count < CNT_W'(DEPTH));

`ifdef PFQ_HALT_STOP_EN
  logic is_halt;
  assign is_halt = (mem_rdata[15:11] == 5'b00001);
`else
  assign fetch_stopped = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) begin
        pc_mem[wr_ptr]   <= mem_addr;
        data_mem[wr_ptr] <= mem_rdata;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      count <= next_count;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      fetch_pc <= '0;
`ifdef PFQ_HALT_STOP_EN
      fetch_stopped <= 1'b0;
`endif
    end else if (flush) begin
      fetch_pc <= flush_pc;
`ifdef PFQ_HALT_STOP_EN
      fetch_stopped <= 1'b0;
`endif
      // An un-acked request must stay on the bus; its data is dropped later.
      if ((state == WAIT || state == DISCARD) && !mem_ack) begin
        state <= DISCARD;
      end else if (enable) begin
        state    <= WAIT;
        mem_req  <= 1'b1;
        mem_addr <= flush_pc;
      end else begin
        state   <= IDLE;
        mem_req <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (enable && has_space) begin
            state    <= WAIT;
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            fetch_pc <= mem_addr + 1'b1;
`ifdef PFQ_HALT_STOP_EN
            if (is_halt) begin
              state         <= STOP;
              mem_req       <= 1'b0;
              fetch_stopped <= 1'b1;
            end else
`endif
            if (enable && has_space) begin
              mem_addr <= mem_addr + 1'b1;
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (mem_ack) begin
            if (enable) begin
              state    <= WAIT;
              mem_addr <= fetch_pc;
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end
          end
        end
`ifdef PFQ_HALT_STOP_EN
        STOP: begin
          state <= STOP;
        end
`endif
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_queue.sv
`default_nettype none
// Bench for instr_prefetch_queue: directed redirect/fill/wrap/halt scenarios, then random traffic
// against a queue-level reference model with a variable-latency memory.
module tb_instr_prefetch_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] flush_pc = '0;
  logic              deq_ready = 1'b0;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              deq_valid;
  logic [DATA_W-1:0] deq_data;
  logic [ADDR_W-1:0] deq_pc;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              fetch_stopped;

  always #5 clock = ~clock;

  instr_prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset), .enable(enable), .flush(flush), .flush_pc(flush_pc),
    .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_data(deq_data), .deq_pc(deq_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fetch_stopped(fetch_stopped)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of {pc, word}, the next address expected to be kept, and stale-return flag.
  typedef struct packed {logic [7:0] pc; logic [15:0] data;} entry_t;
  entry_t      q[$];
  logic        discard = 1'b0;
  logic [7:0]  exp_pc = '0;
  logic        halted = 1'b0;
  logic [15:0] memarr [256];
  int          lat_fixed = 0;
  int          pend = -1;

  task automatic model_reset();
    q.delete();
    discard = 1'b0;
    exp_pc  = '0;
    halted  = 1'b0;
    pend    = -1;
  endtask

  task automatic tick();
    logic s_flush, s_en, s_rdy, s_ack, s_req, exp_req;
    logic [7:0]  s_fpc, s_addr;
    logic [15:0] s_rdata;
    s_flush = flush; s_en = enable; s_rdy = deq_ready; s_ack = mem_ack; s_req = mem_req;
    s_fpc = flush_pc; s_addr = mem_addr; s_rdata = mem_rdata;
    @(posedge clock);
    #1;
    if (s_flush) begin
      q.delete();
      discard = s_req && !s_ack;
      exp_pc  = s_fpc;
      halted  = 1'b0;
    end else begin
      if (s_rdy && q.size() > 0) void'(q.pop_front());
      if (s_req && s_ack) begin
        if (discard) begin
          discard = 1'b0;
        end else begin
          check("fetch_addr", s_addr, exp_pc);
          q.push_back({s_addr, s_rdata});
          exp_pc = s_addr + 8'd1;
`ifdef PFQ_HALT_STOP_EN
          if (s_rdata[15:11] == 5'b00001) halted = 1'b1;
`endif
        end
      end
    end
    check("occupancy", 32'(q.size() <= DEPTH), 1);
    check("deq_valid", deq_valid, 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("deq_pc", deq_pc, q[0].pc);
      check("deq_data", deq_data, q[0].data);
    end
    check("fetch_stopped", fetch_stopped, halted);
    if (s_req && !s_ack) begin
      check("req_hold", mem_req, 1);
      check("addr_hold", mem_addr, s_addr);
    end else if (s_flush) begin
      check("flush_req", mem_req, s_en);
      if (s_en) check("flush_addr", mem_addr, s_fpc);
    end else begin
      exp_req = !halted && s_en && (q.size() < DEPTH);
      check("req", mem_req, exp_req);
      if (exp_req) check("req_addr", mem_addr, exp_pc);
    end
    // Memory: ack after a per-request latency (0 = next cycle), data valid with the ack.
    if (mem_req) begin
      if (pend < 0) pend = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 2));
      if (pend == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = memarr[mem_addr];
        pend      = -1;
      end else begin
        mem_ack = 1'b0;
        pend--;
      end
    end else begin
      mem_ack = 1'b0;
      pend    = -1;
    end
  endtask

  task automatic tick_until_flag(input string tag, input int which, input int limit);
    int n;
    n = 0;
    while (n < limit && !((which == 0 && mem_req && mem_addr == 8'h02 && !mem_ack) ||
                          (which == 1 && mem_req && mem_addr == 8'h40) ||
                          (which == 2 && deq_valid) ||
                          (which == 3 && mem_ack && deq_valid))) begin
      tick();
      n++;
    end
    check(tag, 32'(n < limit), 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      memarr[i] = 16'($urandom);
      if (memarr[i][15:11] == 5'b00001) memarr[i][15] = 1'b1;
    end
    #12;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_deq_valid", deq_valid, 0);
    check("rst_deq_data", deq_data, 0);
    check("rst_deq_pc", deq_pc, 0);
    check("rst_stopped", fetch_stopped, 0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1; enable = 1'b1; deq_ready = 1'b0; lat_fixed = 0;

    // Fill with a 0-wait memory and no dequeue
    repeat (6) tick();
    check("fill_req_off", mem_req, 0);
    check("fill_count", 32'(dut.count), 4);
    check("fill_head_pc", deq_pc, 8'h00);

    // Refill one slot
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    check("refill_head", deq_pc, 8'h01);
    check("refill_req", mem_req, 1);
    check("refill_addr", mem_addr, 8'h04);
    tick();
    check("refill_single", mem_req, 0);
    tick();
    check("refill_stay_off", mem_req, 0);

    // Flush while a request is outstanding
    lat_fixed = 3; deq_ready = 1'b1; flush = 1'b1; flush_pc = 8'h00;
    tick();
    flush = 1'b0;
    tick_until_flag("reach_wait_addr2", 0, 60);
    flush = 1'b1; flush_pc = 8'h40;
    tick();
    flush = 1'b0; lat_fixed = 0;
    check("fw_valid", deq_valid, 0);
    check("fw_req_held", mem_req, 1);
    check("fw_addr_held", mem_addr, 8'h02);
    tick_until_flag("fw_reach_0x40", 1, 20);
    tick_until_flag("fw_first_word", 2, 20);
    check("fw_head_pc", deq_pc, 8'h40);

    // Flush colliding with an ack and a dequeue
    tick_until_flag("ack_and_valid", 3, 20);
    flush = 1'b1; flush_pc = 8'h10;
    tick();
    flush = 1'b0;
    check("fa_valid", deq_valid, 0);
    check("fa_req", mem_req, 1);
    check("fa_addr", mem_addr, 8'h10);

    // Address wrap, also exercising one-word-per-cycle streaming
    flush = 1'b1; flush_pc = 8'hFE;
    tick();
    flush = 1'b0;
    tick_until_flag("wrap_first", 2, 10);
    check("wrap_pc0", deq_pc, 8'hFE);
    tick();
    check("wrap_pc1", deq_pc, 8'hFF);
    tick();
    check("wrap_pc2", deq_pc, 8'h00);

    // HALT word at address 5
    memarr[5] = 16'h0800;
    flush = 1'b1; flush_pc = 8'h00;
    tick();
    flush = 1'b0;
    repeat (12) tick();
`ifdef PFQ_HALT_STOP_EN
    check("halt_stopped", fetch_stopped, 1);
    check("halt_no_req", mem_req, 0);
    check("halt_drained", deq_valid, 0);
`else
    check("halt_ignored", fetch_stopped, 0);
    check("halt_fetching", mem_req, 1);
`endif
    flush = 1'b1; flush_pc = 8'h20;
    tick();
    flush = 1'b0;
    check("resume_stopped", fetch_stopped, 0);
    check("resume_req", mem_req, 1);
    check("resume_addr", mem_addr, 8'h20);

    // Asynchronous reset mid-stream; a stale ack is presented across release
    lat_fixed = 1;
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    check("arst_req", mem_req, 0);
    check("arst_addr", mem_addr, 0);
    check("arst_valid", deq_valid, 0);
    check("arst_data", deq_data, 0);
    model_reset();
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    @(posedge clock);
    #1;
    reset = 1'b1;
    tick();

    // Random traffic
    lat_fixed = -1;
    for (int c = 0; c < 3000; c++) begin
      enable    = ($urandom_range(0, 9) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      flush_pc  = 8'($urandom);
      deq_ready = ($urandom_range(0, 9) < 6);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
